// File: rtl/booth_mul_r4.sv
// Radix-4 Booth sequential multiplier, signed/unsigned operands.
// Optional early termination: define BOOTH_EARLY_TERM_EN.
module booth_mul_r4 #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           tc,
  input  logic [N-1:0]   a_in,
  input  logic [N-1:0]   b_in,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int W  = N + 2;
  localparam int CW = $clog2(N/2 + 2);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W:0]    r_acc;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_m;
  logic          r_qm1;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_a_ext;
  logic [W-1:0]  w_b_ext;
  logic [W:0]    w_m1;
  logic [W:0]    w_m2;
  logic [W:0]    w_sum;
  logic [W:0]    w_acc_n;
  logic [W-1:0]  w_q_n;
  logic          w_qm1_n;
  logic [CW-1:0] w_cnt_n;
  logic          w_last;
  logic [2*N-1:0] w_prod;

  assign w_a_ext = {{2{tc & a_in[N-1]}}, a_in};
  assign w_b_ext = {{2{tc & b_in[N-1]}}, b_in};
  assign w_m1    = {r_m[W-1], r_m};
  assign w_m2    = {r_m, 1'b0};

  always_comb begin
    w_sum = r_acc;
    unique case ({r_q[1:0], r_qm1})
      3'b001, 3'b010: w_sum = r_acc + w_m1;
      3'b011:         w_sum = r_acc + w_m2;
      3'b100:         w_sum = r_acc - w_m2;
      3'b101, 3'b110: w_sum = r_acc - w_m1;
      default:        w_sum = r_acc;
    endcase
  end

  // {acc,Q,Q(-1)} arithmetic shift right by two
  assign w_acc_n = {{2{w_sum[W]}}, w_sum[W:2]};
  assign w_q_n   = {w_sum[1:0], r_q[W-1:2]};
  assign w_qm1_n = r_q[1];
  assign w_cnt_n = r_cnt - 1'b1;

`ifdef BOOTH_EARLY_TERM_EN
  logic [W-1:0]     w_mask;
  logic             w_rest_0;
  logic             w_rest_1;
  logic signed [2*W:0] w_full;

  // Unconsumed multiplier bits sit in the low 2*remaining bits of Q
  assign w_mask   = ~({W{1'b1}} << {w_cnt_n, 1'b0});
  assign w_rest_0 = ((w_q_n & w_mask) == '0) && !w_qm1_n;
  assign w_rest_1 = ((w_q_n & w_mask) == w_mask) && w_qm1_n;
  assign w_last   = (w_cnt_n == '0) || w_rest_0 || w_rest_1;
  assign w_full   = {r_acc, r_q};
  assign w_prod   = (2*N)'(w_full >>> {r_cnt, 1'b0});
`else
  assign w_last   = (w_cnt_n == '0);
  assign w_prod   = {r_acc[N-3:0], r_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = CALC;
      CALC:    if (w_last) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_qm1   <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_m   <= w_a_ext;
            r_q   <= w_b_ext;
            r_acc <= '0;
            r_qm1 <= 1'b0;
            r_cnt <= CW'(N/2 + 1);
            busy  <= 1'b1;
          end
        end
        CALC: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_qm1 <= w_qm1_n;
          r_cnt <= w_cnt_n;
        end
        FIN: begin
          product <= w_prod;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
